// File: rtl/out_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : out_uart_pkg
//  Description : Shared types, constants and helpers for the out_uart_tx
//                serial output peripheral.
//                - tx_state_t      : byte serializer states
//                - UART_IDLE_LEVEL : level of the line between frames
//                - ASCII_NL        : newline appended to each ASCII word
//                - hex_ascii()     : nibble to uppercase ASCII hex digit
//  Revision    : 1.0  initial release
// ============================================================================
package out_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic       UART_IDLE_LEVEL = 1'b1;
    localparam logic [7:0] ASCII_NL        = 8'h0A;

    // '0'-'9' -> 0x30-0x39, 'A'-'F' -> 0x41-0x46
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage : out_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 transmitter for a single byte. A byte is accepted when
//                load is high while ready is high. ready is also high on the
//                final cycle of a STOP bit so that a following byte can be
//                chained with no idle gap on the line.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                load   - accept data (only honoured while ready)
//                data   - byte to transmit, LSB first
//                ready  - can accept a byte on the next edge
//                idle   - serializer is in IDLE (no frame on the line)
//                tx     - registered serial output, idle high
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import out_uart_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       idle,
    output logic       tx
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);
    assign idle    = (state == IDLE);
    assign ready   = idle || ((state == STOP) && bit_end);

    // tx is registered and updated on the same edge as the state change,
    // so the line moves exactly at state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            tx      <= UART_IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= START;
                        cnt   <= '0;
                        shreg <= data;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= UART_IDLE_LEVEL;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (load) begin
                            state <= START;
                            shreg <= data;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= UART_IDLE_LEVEL;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tx    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/out_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : out_uart_tx
//  Description : Watches the CPU out port, queues every new value in a small
//                FIFO and sends each word on a UART TX line (8N1), most
//                significant byte first.
//                Build option: define OUT_UART_ASCII_EN to send each word as
//                DATA_WIDTH/4 uppercase ASCII hex digits followed by 0x0A
//                instead of raw bytes.
//  Ports       : clk     - system clock, shared with the CPU
//                rst_n   - asynchronous active-low reset
//                out_in  - CPU out port value
//                tx      - UART serial line, idle high
//                busy    - frame on the line or FIFO non-empty
//                dropped - sticky, a value arrived while the FIFO was full
//  Revision    : 1.0  initial release
// ============================================================================
module out_uart_tx
    import out_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] out_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef OUT_UART_ASCII_EN
    localparam int NCHARS = DATA_WIDTH / 4;
    localparam int NBYTES = NCHARS + 1;
`else
    localparam int NBYTES = DATA_WIDTH / 8;
`endif
    localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    // Byte number idx of a word, in transmission order.
    function automatic logic [7:0] pick_byte(input logic [DATA_WIDTH-1:0] w,
                                             input logic [IW-1:0]         idx);
`ifdef OUT_UART_ASCII_EN
        if (int'(idx) >= NCHARS) begin
            return ASCII_NL;
        end
        return hex_ascii(4'(w >> (4 * (NCHARS - 1 - int'(idx)))));
`else
        return 8'(w >> (8 * (NBYTES - 1 - int'(idx))));
`endif
    endfunction

    // ------------------------------------------------------------------
    // Change detector
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] prev;
    logic                  push_req;

    assign push_req = (out_in != prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= out_in;
        end
    end

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // still accepted; the head is consumed before the slot is overwritten.
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= out_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dropped <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && full && !pop) begin
                dropped <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word-to-byte sequencing
    // ------------------------------------------------------------------
    logic                  word_active;
    logic [IW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  byte_ready;
    logic                  byte_idle;
    logic                  start_word;
    logic                  next_byte;
    logic                  load;
    logic [7:0]            load_data;

    // A new word is only taken from a fully idle serializer, which gives the
    // one IDLE cycle between consecutive words.
    assign start_word = !word_active && byte_idle && !empty;
    assign next_byte  = word_active && byte_ready && (byte_idx != LAST_IDX);
    assign pop        = start_word;
    assign load       = start_word || next_byte;
    assign load_data  = start_word ? pick_byte(head, '0)
                                   : pick_byte(word, byte_idx + 1'b1);
    assign busy       = word_active || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_active <= 1'b0;
            byte_idx    <= '0;
            word        <= '0;
        end else if (start_word) begin
            word_active <= 1'b1;
            byte_idx    <= '0;
            word        <= head;
        end else if (next_byte) begin
            byte_idx <= byte_idx + 1'b1;
        end else if (word_active && byte_ready) begin
            // Last STOP bit ends: the serializer falls back to IDLE
            word_active <= 1'b0;
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (load_data),
        .ready (byte_ready),
        .idle  (byte_idle),
        .tx    (tx)
    );

endmodule : out_uart_tx
`default_nettype wire

// File: tb/tb_out_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_out_uart_tx
//  Description : Self-checking bench for out_uart_tx (DATA_WIDTH=16,
//                CLK_DIV=4, FIFO_DEPTH=4). A queue/timing reference model
//                predicts tx, busy and dropped every cycle; a line receiver
//                decodes bytes for the directed scenarios.
//                Honours OUT_UART_ASCII_EN for the expected byte stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_out_uart_tx;

    localparam int DATA_WIDTH = 16;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef OUT_UART_ASCII_EN
    localparam int NB = DATA_WIDTH / 4 + 1;
`else
    localparam int NB = DATA_WIDTH / 8;
`endif
    localparam int WORD_CYC = NB * 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] out_in = 16'h0000;
    logic        tx;
    logic        busy;
    logic        dropped;

    always #5 clk = ~clk;

    out_uart_tx #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .out_in  (out_in),
        .tx      (tx),
        .busy    (busy),
        .dropped (dropped)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of words plus the time window of the word on
    // the line. Edges are numbered from 1 after each reset.
    // ------------------------------------------------------------------
    logic [15:0] m_q[$];
    logic [15:0] m_prev;
    bit          m_dropped;
    int          cyc;
    int          m_pop_edge;
    int          m_line_end;
    logic [7:0]  m_bytes[NB];

    function automatic void word_bytes(input logic [15:0] w, output logic [7:0] bb[NB]);
        string hex;
        hex = "0123456789ABCDEF";
`ifdef OUT_UART_ASCII_EN
        for (int i = 0; i < DATA_WIDTH / 4; i++)
            bb[i] = hex[int'((w >> (4 * (DATA_WIDTH / 4 - 1 - i))) & 16'hF)];
        bb[NB - 1] = 8'h0A;
`else
        for (int i = 0; i < NB; i++)
            bb[i] = 8'((w >> (8 * (NB - 1 - i))) & 16'hFF);
`endif
    endfunction

    function automatic logic exp_tx();
        int off, slot, b, j;
        if (cyc < m_pop_edge || cyc >= m_line_end) return 1'b1;
        off  = cyc - m_pop_edge;
        slot = off / CLK_DIV;
        b    = slot / 10;
        j    = slot % 10;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_bytes[b][j - 1];
    endfunction

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_prev     = 16'h0;
            m_dropped  = 1'b0;
            cyc        = 0;
            m_pop_edge = 0;
            m_line_end = 0;
        end else begin
            cyc++;
            if (cyc > m_line_end && m_q.size() > 0) begin
                word_bytes(m_q.pop_front(), m_bytes);
                m_pop_edge = cyc;
                m_line_end = cyc + WORD_CYC;
            end
            if (out_in != m_prev) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(out_in);
                else m_dropped = 1'b1;
            end
            m_prev = out_in;
        end
        #1;
        check_val("tx", 32'(tx), 32'(exp_tx()));
        check_val("busy", 32'(busy), 32'((m_q.size() > 0) || (cyc < m_line_end)));
        check_val("dropped", 32'(dropped), 32'(m_dropped));
    end

    // ------------------------------------------------------------------
    // Line receiver: samples each bit near its centre
    // ------------------------------------------------------------------
    logic [7:0] rx_q[$];

    always begin : p_rx
        logic [7:0] b;
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            repeat (CLK_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                b[i] = tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            rx_q.push_back(b);
        end
    end

    logic [15:0] exp_words[$];

    task automatic check_rx(input string tag);
        logic [7:0] exp[$];
        logic [7:0] bb[NB];
        foreach (exp_words[i]) begin
            word_bytes(exp_words[i], bb);
            foreach (bb[j]) exp.push_back(bb[j]);
        end
        check_val({tag, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
        foreach (exp[i])
            check_val($sformatf("%s_byte%0d", tag, i),
                      (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
        rx_q.delete();
        exp_words.delete();
    endtask

    // Returns the edge number after which busy was first seen low.
    task automatic wait_idle(input string tag, input int max_cyc, output int fall_edge);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        fall_edge = cyc;
        check_val({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        out_in = 16'h0;
        #1;
        check_val("rst_tx", 32'(tx), 32'h1);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_dropped", 32'(dropped), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : p_watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int          n;
        int          fall;
        int          sel;
        logic [15:0] v;
        logic [15:0] old;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with out_in held at the CPU reset value
        repeat (200) @(negedge clk);
        check_val("idle_tx", 32'(tx), 32'h1);
        check_val("idle_busy", 32'(busy), 32'h0);
        check_val("idle_rx", 32'(rx_q.size()), 32'h0);

        // Single word: first edge pushes, second edge starts the frame
        n = cyc;
        out_in = 16'hA55A;
        @(posedge clk); #1;
        check_val("a55a_push_tx", 32'(tx), 32'h1);
        check_val("a55a_busy_rise", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check_val("a55a_tx_fall", 32'(tx), 32'h0);
        wait_idle("a55a", 400, fall);
        check_val("a55a_busy_fall", 32'(fall - n), 32'(2 + WORD_CYC));
        exp_words.push_back(16'hA55A);
        check_rx("a55a");

        // Burst of one change per cycle: the sixth value overflows
        for (int i = 1; i <= 6; i++) begin
            out_in = 16'(i);
            @(negedge clk);
        end
        wait_idle("burst", 6 * (WORD_CYC + 1) + 20, fall);
        check_val("burst_dropped", 32'(dropped), 32'h1);
        for (int i = 1; i <= 5; i++) exp_words.push_back(16'(i));
        repeat (100) @(negedge clk);
        check_rx("burst");

        // Asynchronous reset in the middle of the first data byte
        do_reset();
        out_in = 16'h1234;
        repeat (15) @(negedge clk);
        do_reset();
        repeat (60) @(negedge clk);
        rx_q.delete();
        repeat (100) @(negedge clk);
        check_val("post_rst_rx", 32'(rx_q.size()), 32'h0);
        check_val("post_rst_busy", 32'(busy), 32'h0);

        // Word with a zero nibble/byte and a letter digit
        out_in = 16'h00F3;
        wait_idle("w00f3", 400, fall);
        exp_words.push_back(16'h00F3);
        repeat (10) @(negedge clk);
        check_rx("w00f3");

        // Push into a full FIFO on the same edge as a pop
        @(negedge clk);
        do_reset();
        out_in = 16'h1111; @(negedge clk);
        out_in = 16'h2222; @(negedge clk);
        out_in = 16'h3333; @(negedge clk);
        out_in = 16'h4444; @(negedge clk);
        out_in = 16'h5555; @(negedge clk);
        check_val("full_dropped0", 32'(dropped), 32'h0);
        n = 0;
        while (cyc != m_line_end && n < 500) begin
            @(negedge clk);
            n++;
        end
        out_in = 16'h6666;
        wait_idle("fullpop", 6 * (WORD_CYC + 1) + 20, fall);
        check_val("fullpop_dropped", 32'(dropped), 32'h0);
        exp_words.push_back(16'h1111); exp_words.push_back(16'h2222);
        exp_words.push_back(16'h3333); exp_words.push_back(16'h4444);
        exp_words.push_back(16'h5555); exp_words.push_back(16'h6666);
        repeat (10) @(negedge clk);
        check_rx("fullpop");

        // Random changes, holds and one-cycle glitches
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 9));
            v   = 16'($urandom);
            old = out_in;
            if (sel == 2) v = 16'h0;
            out_in = v;
            if (sel < 2) begin
                @(negedge clk);
                out_in = old;
            end
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end
        wait_idle("random", 6 * (WORD_CYC + 1) + 20, fall);
        check_val("final_tx", 32'(tx), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_out_uart_tx
`default_nettype wire
